// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Latency: none (declarations only).
// Backpressure: not applicable.
package lsu_pkg;

  // RISC-V funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RMW_READ = 3'd2,
    WRITE    = 3'd3,
    RESP     = 3'd4
  } lsu_state_t;

  // Halfwords need an even address and words a 4-byte aligned one; bytes never misalign.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane extraction with sign/zero extension, and sub-word store merge.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module lsu_lane_align #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_word
);
  import lsu_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword out of the memory word
  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  // Extend the selected lane to a full register value
  always_comb begin
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_H:    load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_sel};
      default: load_data = word;
    endcase
  end

  // Overwrite only the addressed lane; full-word stores pass wdata through
  always_comb begin
    store_word = word;
    case (funct3[1:0])
      2'b00: begin
        case (addr_lo)
          2'd0: store_word[7:0]   = wdata[7:0];
          2'd1: store_word[15:8]  = wdata[7:0];
          2'd2: store_word[23:16] = wdata[7:0];
          2'd3: store_word[31:24] = wdata[7:0];
          default: store_word = word;
        endcase
      end
      2'b01: begin
        if (addr_lo[1]) begin
          store_word[31:16] = wdata[15:0];
        end else begin
          store_word[15:0] = wdata[15:0];
        end
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-indexed memory with combinational read, synchronous write.
// Latency: load 2, SW 2, SB/SH 3 (read-modify-write), error 1 cycle after acceptance.
// Backpressure: req_ready low whenever busy; responses cannot be stalled.
module load_store_unit #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_read_en,
  output logic            mem_write_en,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);
  import lsu_pkg::*;

  localparam logic [XLEN-1:0] DEPTH = XLEN'(ADDR_LEN);

  lsu_state_t      state;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;   // store data, replaced by the merged word after RMW read
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic [XLEN-1:0] req_idx;
  logic [XLEN-1:0] idx_q;
  logic            f3_bad;
  logic            req_err;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged_word;

  assign req_idx = {2'b00, req_addr[XLEN-1:2]};
  assign idx_q   = {2'b00, addr_q[XLEN-1:2]};

  // Classify the incoming request: bad funct3 for its direction, misaligned, or out of range
  always_comb begin
    f3_bad = 1'b1;
    case (req_funct3)
      F3_B, F3_H, F3_W: f3_bad = 1'b0;
      F3_BU, F3_HU:     f3_bad = req_we;  // unsigned variants exist only for loads
      default:          f3_bad = 1'b1;
    endcase
    req_err = f3_bad
            | is_misaligned(req_funct3, req_addr[1:0])
            | (req_idx >= DEPTH);
  end

  lsu_lane_align #(.XLEN(XLEN)) u_lane_align (
    .word       (mem_rdata),
    .addr_lo    (addr_q[1:0]),
    .funct3     (f3_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (merged_word)
  );

  // Request sequencing: accept in IDLE, then read / merge / write, then a one-cycle response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= req_err;
            if (req_err) begin
              state <= RESP;
            end else if (!req_we) begin
              state <= LOAD;
            end else if (req_funct3 == F3_W) begin
              state <= WRITE;
            end else begin
              state <= RMW_READ;
            end
          end
        end
        LOAD: begin
          rdata_q <= load_data;
          state   <= RESP;
        end
        RMW_READ: begin
          wdata_q <= merged_word;
          state   <= WRITE;
        end
        WRITE: begin
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake and response outputs come straight off the state register
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    resp_rdata = (state == RESP) ? rdata_q : '0;
    resp_err   = (state == RESP) & err_q;
  end

  // Memory port is decoded from state and latched request only, so reset kills it at once
  always_comb begin
    mem_read_en  = (state == LOAD) || (state == RMW_READ);
    mem_write_en = (state == WRITE);
    mem_addr     = (mem_read_en || mem_write_en) ? idx_q : '0;
    mem_wdata    = mem_write_en ? wdata_q : '0;
  end

  // we_q is kept for debug visibility of the accepted request direction
  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory and scoreboards.
// Latency: checks response, read and write cycles against the acceptance cycle.
// Backpressure: holds req_valid across a busy period to exercise req_ready.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int XLEN     = 32;
  localparam int ADDR_LEN = 1024;

  logic            clk;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic            mem_read_en;
  logic            mem_write_en;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  logic [31:0] mem [ADDR_LEN];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } resp_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } mem_exp_t;

  resp_exp_t resp_q[$];
  mem_exp_t  rd_q[$];
  mem_exp_t  wr_q[$];

  int    n_cmp;
  int    n_fail;
  int    cyc;
  int    n_writes;
  string cur;

  load_store_unit #(.XLEN(XLEN), .ADDR_LEN(ADDR_LEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  assign mem_rdata = (mem_read_en && (mem_addr < 32'(ADDR_LEN))) ? mem[mem_addr[9:0]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One sample of the DUT outputs, taken on the falling edge
  task automatic mon_step();
    resp_exp_t r;
    mem_exp_t  m;
    check("rw_exclusive", 32'(mem_read_en & mem_write_en), 32'd0);
    if (!mem_read_en && !mem_write_en) begin
      check("idle_mem_addr", mem_addr, 32'd0);
      check("idle_mem_wdata", mem_wdata, 32'd0);
    end
    if (mem_read_en) begin
      check({cur, ":read_expected"}, 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) begin
        m = rd_q.pop_front();
        check({cur, ":read_addr"}, mem_addr, m.addr);
        check({cur, ":read_cycle"}, 32'(cyc), 32'(m.due));
      end
    end
    if (mem_write_en) begin
      n_writes++;
      check({cur, ":write_expected"}, 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        m = wr_q.pop_front();
        check({cur, ":write_addr"}, mem_addr, m.addr);
        check({cur, ":write_data"}, mem_wdata, m.data);
        check({cur, ":write_cycle"}, 32'(cyc), 32'(m.due));
      end
    end
    if (resp_valid) begin
      check({cur, ":resp_expected"}, 32'(resp_q.size() != 0), 32'd1);
      if (resp_q.size() != 0) begin
        r = resp_q.pop_front();
        check({cur, ":resp_rdata"}, resp_rdata, r.rdata);
        check({cur, ":resp_err"}, 32'(resp_err), 32'(r.err));
        check({cur, ":resp_cycle"}, 32'(cyc), 32'(r.due));
      end
    end
  endtask

  // Wait (bounded) until every outstanding expectation has been seen, then let the DUT return to IDLE
  task automatic drain();
    int n;
    n = 0;
    while ((resp_q.size() + rd_q.size() + wr_q.size()) != 0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({cur, ":drain_pending"}, 32'(resp_q.size() + rd_q.size() + wr_q.size()), 32'd0);
    resp_q.delete();
    rd_q.delete();
    wr_q.delete();
    @(negedge clk);
  endtask

  // Push the expected schedule for one request; cycle k is the acceptance cycle
  task automatic expect_req(input int k, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                            input logic [31:0] exp_word);
    logic [31:0] idx;
    idx = addr >> 2;
    if (exp_err) begin
      resp_q.push_back('{32'h0, 1'b1, k + 1});
    end else if (!we) begin
      rd_q.push_back('{idx, 32'h0, k + 1});
      resp_q.push_back('{exp_rdata, 1'b0, k + 2});
    end else if (f3 == F3_W) begin
      wr_q.push_back('{idx, wdata, k + 1});
      resp_q.push_back('{32'h0, 1'b0, k + 2});
    end else begin
      rd_q.push_back('{idx, 32'h0, k + 1});
      wr_q.push_back('{idx, exp_word, k + 2});
      resp_q.push_back('{32'h0, 1'b0, k + 3});
    end
  endtask

  // Issue one request at a falling edge and run it to completion
  task automatic do_req(input string name, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                        input logic [31:0] exp_word);
    cur        = name;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    check({name, ":req_ready"}, 32'(req_ready), 32'd1);
    expect_req(cyc, we, f3, addr, wdata, exp_rdata, exp_err, exp_word);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    drain();
  endtask

  task automatic check_quiet(input string name);
    check({name, ":req_ready"}, 32'(req_ready), 32'd1);
    check({name, ":resp_valid"}, 32'(resp_valid), 32'd0);
    check({name, ":resp_rdata"}, resp_rdata, 32'd0);
    check({name, ":resp_err"}, 32'(resp_err), 32'd0);
    check({name, ":mem_read_en"}, 32'(mem_read_en), 32'd0);
    check({name, ":mem_write_en"}, 32'(mem_write_en), 32'd0);
    check({name, ":mem_addr"}, mem_addr, 32'd0);
    check({name, ":mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    int k;
    int w0;
    n_cmp      = 0;
    n_fail     = 0;
    cyc        = 0;
    n_writes   = 0;
    cur        = "reset";
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    for (int i = 0; i < ADDR_LEN; i++) mem[i] = 32'h0;
    mem[4]    = 32'h8899AABB;
    mem[1023] = 32'h0BADF00D;

    fork
      forever begin @(posedge clk); cyc++; end
      forever begin
        @(posedge clk);
        if (mem_write_en && (mem_addr < 32'(ADDR_LEN))) mem[mem_addr[9:0]] <= mem_wdata;
      end
      forever begin @(negedge clk); mon_step(); end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check_quiet("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("after_reset");

    // Loads with every extension flavour
    do_req("lw_10",   1'b0, F3_W,  32'h10, 32'h0, 32'h8899AABB, 1'b0, 32'h0);
    do_req("lb_13",   1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 32'h0);
    do_req("lbu_13",  1'b0, F3_BU, 32'h13, 32'h0, 32'h00000088, 1'b0, 32'h0);
    do_req("lh_12",   1'b0, F3_H,  32'h12, 32'h0, 32'hFFFF8899, 1'b0, 32'h0);
    do_req("lhu_10",  1'b0, F3_HU, 32'h10, 32'h0, 32'h0000AABB, 1'b0, 32'h0);
    do_req("lb_10",   1'b0, F3_B,  32'h10, 32'h0, 32'hFFFFFFBB, 1'b0, 32'h0);
    do_req("lbu_11",  1'b0, F3_BU, 32'h11, 32'h0, 32'h000000AA, 1'b0, 32'h0);
    do_req("lw_last", 1'b0, F3_W,  32'hFFC, 32'h0, 32'h0BADF00D, 1'b0, 32'h0);

    // Sub-word stores via read-modify-write
    do_req("sb_11",   1'b1, F3_B,  32'h11, 32'h12345677, 32'h0, 1'b0, 32'h889977BB);
    do_req("lw_sb",   1'b0, F3_W,  32'h10, 32'h0, 32'h889977BB, 1'b0, 32'h0);
    do_req("sh_12",   1'b1, F3_H,  32'h12, 32'hCAFE1234, 32'h0, 1'b0, 32'h123477BB);
    do_req("lw_sh",   1'b0, F3_W,  32'h10, 32'h0, 32'h123477BB, 1'b0, 32'h0);
    do_req("lb_12",   1'b0, F3_B,  32'h12, 32'h0, 32'h00000034, 1'b0, 32'h0);

    // Error responses: no memory access, one-cycle latency
    do_req("lh_11_mis",  1'b0, F3_H,   32'h11,   32'h0, 32'h0, 1'b1, 32'h0);
    do_req("lw_range",   1'b0, F3_W,   32'h1000, 32'h0, 32'h0, 1'b1, 32'h0);
    do_req("sw_12_mis",  1'b1, F3_W,   32'h12,   32'hDEADBEEF, 32'h0, 1'b1, 32'h0);
    do_req("sh_13_mis",  1'b1, F3_H,   32'h13,   32'hDEADBEEF, 32'h0, 1'b1, 32'h0);
    do_req("store_f3_4", 1'b1, 3'b100, 32'h10,   32'hDEADBEEF, 32'h0, 1'b1, 32'h0);
    do_req("load_f3_3",  1'b0, 3'b011, 32'h10,   32'h0, 32'h0, 1'b1, 32'h0);
    check("errors_left_mem", mem[4], 32'h123477BB);

    // Request held valid while busy: second LW waits for IDLE
    cur        = "busy";
    k          = cyc;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h10;
    req_wdata  = 32'h01020304;
    check("busy:ready_c0", 32'(req_ready), 32'd1);
    expect_req(k, 1'b1, F3_W, 32'h10, 32'h01020304, 32'h0, 1'b0, 32'h0);
    expect_req(k + 3, 1'b0, F3_W, 32'h10, 32'h0, 32'h01020304, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    req_we     = 1'b0;
    req_funct3 = F3_W;
    req_wdata  = 32'h0;
    @(negedge clk);
    check("busy:ready_c1", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("busy:ready_c2", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("busy:ready_c3", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    drain();

    do_req("sw_restore", 1'b1, F3_W, 32'h10, 32'h8899AABB, 32'h0, 1'b0, 32'h0);

    // Reset in the RMW read cycle of SH: no write, response dropped
    cur        = "rst_mid";
    w0         = n_writes;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_H;
    req_addr   = 32'h10;
    req_wdata  = 32'h00005555;
    check("rst_mid:ready", 32'(req_ready), 32'd1);
    rd_q.push_back('{32'd4, 32'h0, cyc + 1});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    #2;
    check("rst_mid:rmw_read_en", 32'(mem_read_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid:read_drop", 32'(mem_read_en), 32'd0);
    check("rst_mid:write_drop", 32'(mem_write_en), 32'd0);
    check("rst_mid:resp_drop", 32'(resp_valid), 32'd0);
    check("rst_mid:addr_drop", mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid:no_write", 32'(n_writes - w0), 32'd0);
    check("rst_mid:mem_kept", mem[4], 32'h8899AABB);
    check("rst_mid:read_seen", 32'(rd_q.size()), 32'd0);
    check_quiet("rst_mid_after");
    repeat (3) @(negedge clk);
    check("rst_mid:late_writes", 32'(n_writes - w0), 32'd0);
    do_req("lw_after_rst", 1'b0, F3_W, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
